// File: rtl/battle_text_pkg.sv
// Shared types and constants for the battle text typewriter: character type,
// name field layout in text RAM and the typer FSM state encoding.
package battle_text_pkg;

  localparam int NAME_LEN = 10;
  localparam int ADDR_W   = 11;

  typedef logic [7:0] char_t;

  localparam char_t CHAR_BLANK = 8'h00;

  localparam logic [ADDR_W-1:0] USER_BASE = 11'd600;
  localparam logic [ADDR_W-1:0] WILD_BASE = 11'd40;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_FILL  = 3'd4,
    ST_FIN   = 3'd5
  } typer_state_t;

endpackage

// File: rtl/frame_pacer.sv
// Counts frame ticks between typed characters; expire_o flags the tick that
// completes the delay, and clear_i restarts the count.
module frame_pacer #(
  parameter int DELAY = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic tick_i,
  output logic expire_o
);

  localparam int CW = (DELAY > 1) ? $clog2(DELAY) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // Expiry and next count
  always_comb begin
    cnt_d    = cnt_q;
    expire_o = 1'b0;
    if (clear_i) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q == CW'(DELAY - 1)) begin
        expire_o = 1'b1;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Tick counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/battle_name_typer.sv
// Typewriter stage: snapshots one name and writes it into battle text RAM,
// paced by frame ticks, blank-filling everything after the first terminator.
module battle_name_typer
  import battle_text_pkg::*;
#(
  parameter int                NAME_LEN   = battle_text_pkg::NAME_LEN,
  parameter int                CHAR_DELAY = 2,
  parameter int                ADDR_W     = battle_text_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] USER_BASE  = battle_text_pkg::USER_BASE,
  parameter logic [ADDR_W-1:0] WILD_BASE  = battle_text_pkg::WILD_BASE
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       frameTick,
  input  logic                       start,
  input  logic                       sideSel,
  input  logic                       skip,
  input  char_t [NAME_LEN-1:0]       userName,
  input  char_t [NAME_LEN-1:0]       wildName,
  output logic                       wrEn,
  output logic [ADDR_W-1:0]          wrAddr,
  output char_t                      wrData,
  output logic                       busy,
  output logic                       done
);

  localparam int              IDX_W = (NAME_LEN > 1) ? $clog2(NAME_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NAME_LEN - 1);

  typer_state_t          state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  side_q, side_d;
  logic                  arm_q;
  char_t [NAME_LEN-1:0]  name_q, name_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
  char_t                 wr_data_q, wr_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pace_clear_s;
  logic                  pace_expire_s;
  logic [ADDR_W-1:0]     base_s;

  assign pace_clear_s = (state_q != ST_WAIT) || skip;

  frame_pacer #(.DELAY(CHAR_DELAY)) u_pacer (
    .clk_i    (Clk),
    .rst_ni   (Reset_n),
    .clear_i  (pace_clear_s),
    .tick_i   (frameTick),
    .expire_o (pace_expire_s)
  );

  // Next state; outputs are derived from the state being entered so they register in step with it
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    side_d  = side_q;
    name_d  = name_q;
    case (state_q)
      ST_IDLE: begin
        // arm_q blocks a start coinciding with reset release
        if (start && arm_q) begin
          state_d = ST_LOAD;
          side_d  = sideSel;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        name_d  = side_q ? wildName : userName;
        idx_d   = '0;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (name_q[idx_q] == CHAR_BLANK) begin
          if (idx_q == LAST) begin
            state_d = ST_FIN;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_FILL;
          end
        end else if (idx_q == LAST) begin
          state_d = ST_FIN;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = skip ? ST_WRITE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (skip || pace_expire_s) begin
          state_d = ST_WRITE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_FILL: begin
        if (idx_q == LAST) begin
          state_d = ST_FIN;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_FILL;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    base_s    = side_d ? WILD_BASE : USER_BASE;
    wr_en_d   = (state_d == ST_WRITE) || (state_d == ST_FILL);
    busy_d    = (state_d == ST_LOAD) || (state_d == ST_WRITE) ||
                (state_d == ST_WAIT) || (state_d == ST_FILL);
    done_d    = (state_d == ST_FIN);
    if (wr_en_d) begin
      wr_addr_d = base_s + ADDR_W'(idx_d);
      wr_data_d = (state_d == ST_FILL) ? CHAR_BLANK : name_d[idx_d];
    end else begin
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
    end
  end

  // FSM state, snapshot buffer and registered outputs
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      side_q    <= 1'b0;
      arm_q     <= 1'b0;
      name_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= CHAR_BLANK;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      side_q    <= side_d;
      arm_q     <= 1'b1;
      name_q    <= name_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign wrEn   = wr_en_q;
  assign wrAddr = wr_addr_q;
  assign wrData = wr_data_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
